// File: rtl/debug_pkg.sv
// Shared types and sizing helpers for the debug trace buffer.
// Provides the capture FSM state type and the entry/index width functions.
package debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_t;

    // Width of one stored entry: {timestamp, change_mask, channel data}.
    function automatic int entry_w(input int num_ch, input int ch_w, input int ts_w);
        return ts_w + num_ch + (num_ch * ch_w);
    endfunction

    // Width of a pointer into a DEPTH-entry buffer.
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the controller.
module trace_ram
    import debug_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write the addressed entry when the controller accepts a trace write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/debug_trace_buffer.sv
// Debug trace buffer: watches NUM_CH channels, records a timestamped entry
// whenever any masked channel changes while armed or capturing, and lets a
// consumer pop entries oldest-first. Wrap or stop behaviour when full.
// Optional build macro: DEBUG_TRACE_DISPLAY_EN prints each written entry
// during simulation; without it the block contains no display code.
module debug_trace_buffer
    import debug_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 10,
    parameter int DEPTH  = 64,
    parameter int TS_W   = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   debug_enable,
    input  logic                                   clear,
    input  logic                                   mode_wrap,
    input  logic                                   trigger,
    input  logic [idx_w(DEPTH):0]                  post_len,
    input  logic [NUM_CH*CH_W-1:0]                 ch_data,
    input  logic [NUM_CH-1:0]                      ch_mask,
    input  logic                                   rd_ready,
    output logic                                   rd_valid,
    output logic [entry_w(NUM_CH, CH_W, TS_W)-1:0] rd_data,
    output logic [idx_w(DEPTH):0]                  count,
    output logic [15:0]                            drop_cnt,
    output logic [1:0]                             state_out,
    output logic                                   triggered
);

    localparam int AW    = idx_w(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int EW    = entry_w(NUM_CH, CH_W, TS_W);
    localparam int DW    = NUM_CH * CH_W;

    // Registered state
    logic [TS_W-1:0]  ts_r;
    logic [DW-1:0]    prev_r;
    trace_state_t     state_r;
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [CNT_W-1:0] count_r;
    logic [15:0]      drop_r;
    logic             trig_r;
    logic [CNT_W-1:0] post_left_r;

    // Combinational controls
    logic [NUM_CH-1:0] change_mask_s;
    logic              wr_req_s;
    logic              pop_s;
    logic              full_s;
    logic              ram_we_s;
    logic              stop_full_s;
    trace_state_t      state_nxt_s;
    logic [AW-1:0]     wptr_nxt_s;
    logic [AW-1:0]     rptr_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [15:0]       drop_nxt_s;
    logic              trig_nxt_s;
    logic [CNT_W-1:0]  post_nxt_s;
    logic [15:0]       drop_inc_s;
    logic [EW-1:0]     wr_entry_s;

    // Flag every participating channel whose value differs from last cycle.
    always_comb begin
        change_mask_s = {NUM_CH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            change_mask_s[k] = ch_mask[k] && (ch_data[k*CH_W +: CH_W] != prev_r[k*CH_W +: CH_W]);
        end
    end

    assign wr_req_s   = (|change_mask_s) && ((state_r == ST_ARMED) || (state_r == ST_CAPTURE));
    assign pop_s      = (count_r != CNT_W'(0)) && rd_ready;
    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign drop_inc_s = (drop_r == 16'hFFFF) ? drop_r : (drop_r + 16'd1);
    assign wr_entry_s = {ts_r, change_mask_s, ch_data};

    // Buffer bookkeeping and capture FSM next-state; clear overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        wptr_nxt_s  = wptr_r;
        rptr_nxt_s  = rptr_r;
        count_nxt_s = count_r;
        drop_nxt_s  = drop_r;
        trig_nxt_s  = trig_r;
        post_nxt_s  = post_left_r;
        ram_we_s    = 1'b0;
        stop_full_s = 1'b0;

        if (clear) begin
            wptr_nxt_s  = {AW{1'b0}};
            rptr_nxt_s  = {AW{1'b0}};
            count_nxt_s = {CNT_W{1'b0}};
            drop_nxt_s  = 16'd0;
            trig_nxt_s  = 1'b0;
            post_nxt_s  = {CNT_W{1'b0}};
            state_nxt_s = debug_enable ? ST_ARMED : ST_IDLE;
        end else begin
            // Datapath: a pop alongside a write always makes room, even when full.
            if (wr_req_s) begin
                if (!full_s || pop_s) begin
                    ram_we_s   = 1'b1;
                    wptr_nxt_s = wptr_r + AW'(1);
                    if (pop_s) begin
                        rptr_nxt_s = rptr_r + AW'(1);
                    end else begin
                        count_nxt_s = count_r + CNT_W'(1);
                    end
                end else if (mode_wrap) begin
                    ram_we_s   = 1'b1;
                    wptr_nxt_s = wptr_r + AW'(1);
                    rptr_nxt_s = rptr_r + AW'(1);
                    drop_nxt_s = drop_inc_s;
                end else begin
                    drop_nxt_s  = drop_inc_s;
                    stop_full_s = 1'b1;
                end
            end else if (pop_s) begin
                rptr_nxt_s  = rptr_r + AW'(1);
                count_nxt_s = count_r - CNT_W'(1);
            end else begin
                count_nxt_s = count_r;
            end

            // FSM: losing debug_enable wins over any other transition.
            if (!debug_enable) begin
                state_nxt_s = ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_nxt_s = ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (stop_full_s) begin
                            state_nxt_s = ST_DONE;
                        end else if (trigger) begin
                            trig_nxt_s = 1'b1;
                            if (post_len == CNT_W'(0)) begin
                                state_nxt_s = ST_DONE;
                            end else begin
                                state_nxt_s = ST_CAPTURE;
                                post_nxt_s  = post_len;
                            end
                        end else begin
                            state_nxt_s = ST_ARMED;
                        end
                    end
                    ST_CAPTURE: begin
                        if (stop_full_s) begin
                            state_nxt_s = ST_DONE;
                        end else if (wr_req_s) begin
                            if (post_left_r <= CNT_W'(1)) begin
                                state_nxt_s = ST_DONE;
                                post_nxt_s  = {CNT_W{1'b0}};
                            end else begin
                                post_nxt_s  = post_left_r - CNT_W'(1);
                            end
                        end else begin
                            state_nxt_s = ST_CAPTURE;
                        end
                    end
                    ST_DONE: begin
                        state_nxt_s = ST_DONE;
                    end
                    default: begin
                        state_nxt_s = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // State, pointer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wptr_r      <= {AW{1'b0}};
            rptr_r      <= {AW{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            drop_r      <= 16'd0;
            trig_r      <= 1'b0;
            post_left_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            wptr_r      <= wptr_nxt_s;
            rptr_r      <= rptr_nxt_s;
            count_r     <= count_nxt_s;
            drop_r      <= drop_nxt_s;
            trig_r      <= trig_nxt_s;
            post_left_r <= post_nxt_s;
        end
    end

    // Free-running timestamp and last-cycle channel snapshot; clear leaves both alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r   <= {TS_W{1'b0}};
            prev_r <= {DW{1'b0}};
        end else begin
            ts_r   <= ts_r + TS_W'(1);
            prev_r <= ch_data;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we_s),
        .wr_addr (wptr_r),
        .wr_data (wr_entry_s),
        .rd_addr (rptr_r),
        .rd_data (rd_data)
    );

`ifdef DEBUG_TRACE_DISPLAY_EN
    // Simulation trace of every entry that lands in storage.
    always_ff @(posedge clk) begin
        if (rst_n && ram_we_s) begin
            $display("trace ts=%0d mask=%h data=%h", ts_r, change_mask_s, ch_data);
        end
    end
`endif

    assign rd_valid  = (count_r != CNT_W'(0));
    assign count     = count_r;
    assign drop_cnt  = drop_r;
    assign state_out = state_r;
    assign triggered = trig_r;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Self-checking bench for debug_trace_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_debug_trace_buffer;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 10;
    localparam int DEPTH  = 4;
    localparam int TS_W   = 8;
    localparam int EW     = TS_W + NUM_CH + NUM_CH * CH_W;
    localparam int CW     = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              debug_enable = 1'b0;
    logic              clear = 1'b0;
    logic              mode_wrap = 1'b0;
    logic              trigger = 1'b0;
    logic [CW-1:0]     post_len = 3'd0;
    logic [39:0]       ch_data = 40'd0;
    logic [3:0]        ch_mask = 4'd0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [EW-1:0]     rd_data;
    logic [CW-1:0]     count;
    logic [15:0]       drop_cnt;
    logic [1:0]        state_out;
    logic              triggered;

    debug_trace_buffer #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .debug_enable (debug_enable),
        .clear        (clear),
        .mode_wrap    (mode_wrap),
        .trigger      (trigger),
        .post_len     (post_len),
        .ch_data      (ch_data),
        .ch_mask      (ch_mask),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .count        (count),
        .drop_cnt     (drop_cnt),
        .state_out    (state_out),
        .triggered    (triggered)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: entries as a queue, state as an integer 0..3.
    logic [EW-1:0] m_q[$];
    int            m_state;
    int            m_ts;
    int            m_drop;
    int            m_post;
    bit            m_trig;
    logic [39:0]   m_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_state = 0;
        m_ts    = 0;
        m_drop  = 0;
        m_post  = 0;
        m_trig  = 1'b0;
        m_prev  = 40'd0;
    endtask

    function automatic logic [3:0] model_mask();
        logic [3:0] mk;
        mk = 4'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_mask[k] && (ch_data[k*CH_W +: CH_W] != m_prev[k*CH_W +: CH_W])) mk[k] = 1'b1;
        end
        return mk;
    endfunction

    task automatic model_step();
        logic [3:0]    mk;
        logic [7:0]    ts8;
        logic [EW-1:0] e;
        bit            wr, pop, stopped;
        mk      = model_mask();
        wr      = (mk != 4'd0) && (m_state == 1 || m_state == 2);
        pop     = (m_q.size() != 0) && rd_ready;
        stopped = 1'b0;
        ts8     = m_ts[7:0];
        e       = {ts8, mk, ch_data};
        if (clear) begin
            m_q.delete();
            m_drop  = 0;
            m_trig  = 1'b0;
            m_post  = 0;
            m_state = debug_enable ? 1 : 0;
        end else begin
            if (wr) begin
                if (m_q.size() < DEPTH || pop) begin
                    if (pop) m_q.delete(0);
                    m_q.push_back(e);
                end else if (mode_wrap) begin
                    m_q.delete(0);
                    m_q.push_back(e);
                    if (m_drop < 65535) m_drop++;
                end else begin
                    stopped = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end else if (pop) begin
                m_q.delete(0);
            end
            if (!debug_enable) begin
                m_state = 0;
            end else begin
                case (m_state)
                    0: m_state = 1;
                    1: begin
                        if (stopped) m_state = 3;
                        else if (trigger) begin
                            m_trig = 1'b1;
                            if (post_len == 3'd0) m_state = 3;
                            else begin
                                m_state = 2;
                                m_post  = int'(post_len);
                            end
                        end
                    end
                    2: begin
                        if (stopped) m_state = 3;
                        else if (wr) begin
                            m_post--;
                            if (m_post == 0) m_state = 3;
                        end
                    end
                    3: m_state = 3;
                    default: m_state = 0;
                endcase
            end
        end
        m_ts   = (m_ts + 1) % 256;
        m_prev = ch_data;
    endtask

    task automatic check_model();
        chk("count", 64'(count), 64'(m_q.size()));
        chk("rd_valid", 64'(rd_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) chk("rd_data", 64'(rd_data), 64'(m_q[0]));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("state", 64'(state_out), 64'(m_state));
        chk("triggered", 64'(triggered), 64'(m_trig));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic set_ch(input int k, input logic [9:0] v);
        ch_data[k*CH_W +: CH_W] = v;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    logic [7:0] exp_ts;

    initial begin
        // Reset state
        model_reset();
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_state", 64'(state_out), 64'd0);
        chk("rst_trig", 64'(triggered), 64'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ch_mask = 4'b1111;
        debug_enable = 1'b1;
        step();
        chk("armed", 64'(state_out), 64'd1);

        // Channel 1 steps 0 -> 5 -> 7: two entries, consecutive timestamps
        exp_ts = m_ts[7:0];
        set_ch(1, 10'd5); step();
        set_ch(1, 10'd7); step();
        chk("d24_count", 64'(count), 64'd2);
        chk("d24_mask", 64'(rd_data[43:40]), 64'h2);
        chk("d24_ts0", 64'(rd_data[51:44]), 64'(exp_ts));
        chk("d24_ch1a", 64'(rd_data[19:10]), 64'd5);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        chk("d24_ts1", 64'(rd_data[51:44]), 64'(8'(exp_ts + 8'd1)));
        chk("d24_ch1b", 64'(rd_data[19:10]), 64'd7);

        // Channels 0 and 2 change together: one entry
        do_clear();
        set_ch(0, 10'd3); set_ch(2, 10'd9); step();
        chk("d25_count", 64'(count), 64'd1);
        chk("d25_mask", 64'(rd_data[43:40]), 64'h5);

        // Wrap mode, 6 changes, no pops
        do_clear();
        mode_wrap = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            set_ch(3, 10'(i)); step();
        end
        chk("d26_count", 64'(count), 64'd4);
        chk("d26_drop", 64'(drop_cnt), 64'd2);
        chk("d26_oldest", 64'(rd_data[39:30]), 64'd3);

        // Stop mode, 5 changes
        do_clear();
        mode_wrap = 1'b0;
        for (int i = 7; i <= 11; i++) begin
            set_ch(3, 10'(i)); step();
        end
        chk("d27_count", 64'(count), 64'd4);
        chk("d27_drop", 64'(drop_cnt), 64'd1);
        chk("d27_state", 64'(state_out), 64'd3);
        chk("d27_oldest", 64'(rd_data[39:30]), 64'd7);

        // post_len=3 capture, second trigger ignored
        do_clear();
        mode_wrap = 1'b1;
        post_len = 3'd3;
        trigger = 1'b1; step(); trigger = 1'b0;
        chk("d28_capture", 64'(state_out), 64'd2);
        chk("d28_trig", 64'(triggered), 64'd1);
        for (int i = 100; i <= 104; i++) begin
            set_ch(0, 10'(i)); step();
        end
        chk("d28_count", 64'(count), 64'd3);
        chk("d28_done", 64'(state_out), 64'd3);
        trigger = 1'b1; step(); trigger = 1'b0;
        chk("d28_retrig", 64'(state_out), 64'd3);

        // Full buffer with write and pop together; clear beats a same-cycle write
        do_clear();
        mode_wrap = 1'b0;
        for (int i = 20; i < 24; i++) begin
            set_ch(2, 10'(i)); step();
        end
        chk("d29_full", 64'(count), 64'd4);
        set_ch(2, 10'd30); rd_ready = 1'b1; step(); rd_ready = 1'b0;
        chk("d29_count", 64'(count), 64'd4);
        chk("d29_drop", 64'(drop_cnt), 64'd0);
        set_ch(2, 10'd31); clear = 1'b1; step(); clear = 1'b0;
        chk("d29_clear", 64'(count), 64'd0);

        // post_len=0 goes straight to DONE; pops still drain in IDLE
        set_ch(1, 10'd40); step();
        set_ch(1, 10'd41); step();
        post_len = 3'd0; trigger = 1'b1; step(); trigger = 1'b0;
        chk("pl0_done", 64'(state_out), 64'd3);
        debug_enable = 1'b0; step();
        chk("idle", 64'(state_out), 64'd0);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        chk("idle_pop", 64'(count), 64'd1);
        debug_enable = 1'b1; step();

        // Randomized traffic, including a reset in the middle
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                rst_n = 1'b0;
                #2;
                model_reset();
                check_model();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            debug_enable = ($urandom_range(0, 19) != 0);
            clear        = ($urandom_range(0, 39) == 0);
            trigger      = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 49) == 0) mode_wrap = ~mode_wrap;
            post_len     = 3'($urandom_range(0, 4));
            ch_mask      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 3) == 0) set_ch(k, 10'($urandom));
            end
            rd_ready     = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/debug_trace_buffer.md
DEBUG_TRACE_BUFFER -- requirements
Module: debug_trace_buffer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of watched channels (1..16).
REQ-002 SHALL have parameter CH_W, default 10, meaning bits per channel.
REQ-003 SHALL have parameter DEPTH, default 64, meaning trace entries, a power of two, at least 4.
REQ-004 SHALL have parameter TS_W, default 16, meaning timestamp width.
REQ-005 SHALL have ports, one per line:
  clk  in  1  single clock; all logic on posedge.
  rst_n  in  1  asynchronous, active-low reset.
  debug_enable  in  1  0 forces IDLE.
  clear  in  1  synchronous flush, pulse.
  mode_wrap  in  1  1 = overwrite oldest when full; 0 = stop when full.
  trigger  in  1  trigger pulse.
  post_len  in  $clog2(DEPTH)+1  entries to record after the trigger.
  ch_data  in  NUM_CH*CH_W  watched values; channel k is at [k*CH_W +: CH_W].
  ch_mask  in  NUM_CH  1 = channel participates in change detection.
  rd_ready  in  1  consumer pop request.
  rd_valid  out  1  count != 0.
  rd_data  out  ENTRY_W  oldest entry, {timestamp, change_mask[NUM_CH], ch_data}.
  count  out  $clog2(DEPTH)+1  entries stored.
  drop_cnt  out  16  dropped entries, saturating at 16'hFFFF.
  state_out  out  2  current FSM state.
  triggered  out  1  a trigger has been accepted since the last clear.

Function
REQ-006 SHALL run a free-running TS_W-bit timestamp that increments every cycle and wraps to 0.
REQ-007 SHALL compute change_mask[k] = ch_mask[k] && (ch_data channel k != its registered previous value); the previous-value register SHALL update every cycle.
REQ-008 SHALL write one entry per cycle when |change_mask is set and the state is ARMED or CAPTURE; all changed channels share that single entry.
REQ-009 SHALL present rd_data combinationally from the read pointer; a pop occurs on rd_valid && rd_ready, and the next entry is visible in the following cycle.
REQ-010 SHALL implement the FSM IDLE(0), ARMED(1), CAPTURE(2), DONE(3):
  IDLE to ARMED when debug_enable is 1.
  ARMED to CAPTURE on trigger.
  CAPTURE to DONE after post_len writes; post_len=0 goes straight to DONE on trigger.
  Any state to IDLE when debug_enable is 0.
REQ-011 SHALL set triggered on the ARMED to CAPTURE transition; a trigger in any other state SHALL be ignored.
REQ-012 SHALL, on a write while full with mode_wrap=1 and no pop, overwrite the oldest entry, advance the read pointer, keep count=DEPTH and increment drop_cnt.
REQ-013 SHALL, on a write while full with mode_wrap=0 and no pop, discard the new entry, increment drop_cnt and go to DONE.
REQ-014 SHALL, on a simultaneous write and pop, store the new entry and retire the oldest, with count unchanged and no drop; this also applies when full.
REQ-015 SHALL let pops continue in every state, including IDLE and DONE.
REQ-016 SHALL, on clear, empty the buffer, zero drop_cnt and triggered, and go to ARMED if debug_enable is 1, else IDLE; clear SHALL take priority over a same-cycle write, pop or trigger.
REQ-017 SHALL let pointers wrap modulo DEPTH with no bubble.

Reset
REQ-018 SHALL, while rst_n is low, asynchronously set state IDLE, pointers 0, count 0, drop_cnt 0, triggered 0, timestamp 0 and the previous-value register 0; rd_valid is therefore 0.
REQ-019 SHALL treat reset mid-capture as a clear; trace contents need not be zeroed.

Configuration
REQ-020 SHALL, with DEBUG_TRACE_DISPLAY_EN defined, $display each written entry in simulation as timestamp, change mask in hex, then channel values.
REQ-021 SHALL, with DEBUG_TRACE_DISPLAY_EN undefined, contain no display code, with identical synthesised logic.

Structure
REQ-022 SHALL take trace_state_t (the FSM enum) and the ENTRY_W/index width functions from package debug_pkg.
REQ-023 SHALL place the storage array (one write port, asynchronous read port) in sub-module trace_ram; control stays in debug_trace_buffer.

Verification
REQ-024 SHALL cover: NUM_CH=4, CH_W=10; channel 1 steps 0, 5, 7 while ARMED -> 2 entries, change_mask 4'b0010, consecutive timestamps.
REQ-025 SHALL cover: channels 0 and 2 change in the same cycle -> one entry, change_mask 4'b0101.
REQ-026 SHALL cover: DEPTH=4, mode_wrap=1, 6 changes and no pops -> count=4, drop_cnt=2, oldest entry is the 3rd change.
REQ-027 SHALL cover: DEPTH=4, mode_wrap=0, 5 changes -> count=4, drop_cnt=1, state DONE.
REQ-028 SHALL cover: post_len=3, trigger, then 5 changes -> 3 entries after the trigger, then DONE; a 2nd trigger is ignored.
REQ-029 SHALL cover: full buffer with simultaneous write and pop -> count stays 4, drop_cnt 0; clear with write in the same cycle -> count 0.
